// File: rtl/control_sequencer.sv
// Fetch/decode/execute controller for the 8-bit accumulator datapath.
// Optional single-step gating of FETCH: SEQUENCER_SINGLE_STEP_EN.
module control_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
`ifdef SEQUENCER_SINGLE_STEP_EN
  input  logic                  iStep,
`endif
  input  logic [15:0]           iInstruction,
  input  logic [DATA_WIDTH-1:0] iRPG,
  input  logic                  iCarry,
  output logic [1:0]            oRPGSelect,
  output logic [DATA_WIDTH-1:0] oInm,
  output logic [1:0]            oAluOp,
  output logic [ADDR_WIDTH-1:0] oMemReadAddr,
  output logic [ADDR_WIDTH-1:0] oMemWriteAddr,
  output logic                  oMemWriteEnable,
  output logic                  oPCEnable,
  output logic                  oPCLoad,
  output logic [ADDR_WIDTH-1:0] oPCTarget,
  output logic                  oHalted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_EXEC,
    S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;
  logic        r_flag;

  logic [3:0]  w_op;
  logic [3:0]  w_in_op;
  logic        w_ldi;
  logic        w_ld;
  logic        w_st;
  logic        w_alu;
  logic        w_jmp;
  logic        w_br;
  logic        w_in_mem;
  logic        w_in_halt;
  logic        w_flag_d;
  logic        w_step;
  logic        w_unused_ir;

  assign w_op    = r_ir[15:12];
  assign w_in_op = iInstruction[15:12];

  assign w_ldi = (w_op == 4'h1);
  assign w_ld  = (w_op == 4'h2);
  assign w_st  = (w_op == 4'h3);
  assign w_alu = (w_op == 4'h4) | (w_op == 4'h5) | (w_op == 4'h6);
  assign w_jmp = (w_op == 4'h7);
  assign w_br  = (w_op == 4'h8) | (w_op == 4'h9);

  assign w_in_mem  = (w_in_op == 4'h2) | (w_in_op == 4'h4) |
                     (w_in_op == 4'h5) | (w_in_op == 4'h6);
  assign w_in_halt = (w_in_op == 4'hF);

  // JZ tests the accumulator, JC the carry; anything else clears it
  assign w_flag_d = (w_in_op == 4'h8) ? (iRPG == '0) :
                    (w_in_op == 4'h9) ? iCarry : 1'b0;

`ifdef SEQUENCER_SINGLE_STEP_EN
  assign w_step = iStep;
`else
  assign w_step = 1'b1;
`endif

  // Fields taken straight from the latched instruction word
  assign oInm          = DATA_WIDTH'(r_ir[7:0]);
  assign oMemReadAddr  = r_ir[ADDR_WIDTH-1:0];
  assign oMemWriteAddr = r_ir[ADDR_WIDTH-1:0];
  assign oPCTarget     = r_ir[ADDR_WIDTH-1:0];
  assign oAluOp        = (w_op == 4'h5) ? 2'd1 :
                         (w_op == 4'h6) ? 2'd2 : 2'd0;
  assign w_unused_ir   = ^r_ir[11:8];

  // State, instruction and branch-flag registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_ir   <= iInstruction;
        r_flag <= w_flag_d;
      end
    end
  end

  // Next state and per-cycle control strobes
  always_comb begin
    w_next          = r_state;
    oRPGSelect      = 2'd3;
    oMemWriteEnable = 1'b0;
    oPCEnable       = 1'b0;
    oPCLoad         = 1'b0;
    oHalted         = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        if (w_step) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_in_mem)       w_next = S_MEM;
        else if (w_in_halt) w_next = S_HALT;
        else                w_next = S_EXEC;
      end
      S_MEM: begin
        w_next = S_EXEC;
      end
      S_EXEC: begin
        w_next = S_FETCH;
        unique case (1'b1)
          w_ldi:   oRPGSelect = 2'd0;
          w_ld:    oRPGSelect = 2'd2;
          w_alu:   oRPGSelect = 2'd1;
          default: oRPGSelect = 2'd3;
        endcase
        oMemWriteEnable = w_st;
        if (w_jmp | (w_br & r_flag)) oPCLoad = 1'b1;
        else                         oPCEnable = 1'b1;
      end
      S_HALT: begin
        oHalted = 1'b1;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

endmodule
